// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: register map, status bit positions,
// the common bit-level FSM state type and the divisor floor.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV_LO = 2'd2;
    localparam logic [1:0] ADDR_DIV_HI = 2'd3;

    localparam int STAT_TX_BUSY   = 0;
    localparam int STAT_RX_VALID  = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

    // Smallest usable bit time; the RX half-bit check needs at least 2 clocks.
    localparam int MIN_DIV = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver with an input synchronizer. Validates the start bit at half a
// bit time, then samples mid-bit; returns to IDLE right after the stop sample.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
)
(
    input  logic             clk,
    input  logic             srst,
    input  logic [DIV_W-1:0] div,
    input  logic             rx_bit,
    output logic [7:0]       rx_data,
    output logic             rx_done,
    output logic             rx_ferr
);

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_reg;
            if (gi == 0) begin : g_in
                always_ff @(posedge clk) begin
                    if (srst) stage_reg <= 1'b1;
                    else      stage_reg <= rx_bit;
                end
            end else begin : g_chain
                always_ff @(posedge clk) begin
                    if (srst) stage_reg <= 1'b1;
                    else      stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    logic rx_sync;
    assign rx_sync = g_sync[SYNC_STAGES-1].stage_reg;

    uart_state_t      state_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] bit_len_reg;
    logic [2:0]       idx_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       data_reg;
    logic             done_reg;
    logic             ferr_reg;
    logic             half_end;
    logic             bit_end;

    assign half_end = (cnt_reg == (bit_len_reg >> 1) - DIV_W'(1));
    assign bit_end  = (cnt_reg == bit_len_reg - DIV_W'(1));
    assign rx_data  = data_reg;
    assign rx_done  = done_reg;
    assign rx_ferr  = ferr_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_len_reg <= DIV_W'(MIN_DIV);
            idx_reg     <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            done_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            ferr_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg     <= '0;
                    bit_len_reg <= div;
                    if (!rx_sync) state_reg <= START;
                end
                START: begin
                    if (half_end) begin
                        cnt_reg     <= '0;
                        bit_len_reg <= div;
                        idx_reg     <= '0;
                        state_reg   <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_reg     <= '0;
                        bit_len_reg <= div;
                        shift_reg   <= {rx_sync, shift_reg[7:1]};
                        idx_reg     <= idx_reg + 3'd1;
                        if (idx_reg == 3'd7) state_reg <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        if (rx_sync) begin
                            data_reg <= shift_reg;
                            done_reg <= 1'b1;
                        end else begin
                            ferr_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: start bit, 8 data bits LSB first, stop bit, each held for
// one bit time. The bit length is re-latched at every bit boundary.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
)
(
    input  logic             clk,
    input  logic             srst,
    input  logic [DIV_W-1:0] div,
    input  logic             start,
    input  logic [7:0]       data,
    output logic             tx_bit,
    output logic             busy
);

    uart_state_t      state_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] bit_len_reg;
    logic [2:0]       idx_reg;
    logic [7:0]       shift_reg;
    logic             tx_reg;
    logic             busy_reg;
    logic             bit_end;

    assign bit_end = (cnt_reg == bit_len_reg - DIV_W'(1));
    assign tx_bit  = tx_reg;
    assign busy    = busy_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_len_reg <= DIV_W'(MIN_DIV);
            idx_reg     <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            if (state_reg != IDLE) begin
                if (bit_end) begin
                    cnt_reg     <= '0;
                    bit_len_reg <= div;
                end else begin
                    cnt_reg <= cnt_reg + DIV_W'(1);
                end
            end

            case (state_reg)
                IDLE: begin
                    tx_reg  <= 1'b1;
                    cnt_reg <= '0;
                    if (start) begin
                        shift_reg   <= data;
                        bit_len_reg <= div;
                        tx_reg      <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_reg    <= shift_reg[0];
                        idx_reg   <= '0;
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        // shift_reg[1] is the next bit before this edge's shift lands
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        tx_reg    <= shift_reg[1];
                        idx_reg   <= idx_reg + 3'd1;
                        if (idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_reg    <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart.sv
// UART top: single-cycle-ack bus slave with divisor and status registers,
// wrapping the transmitter and receiver. wb_clk is a legacy pin, not a clock.
module uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DIV_W        = 16
)
(
    input  logic       clk,
    input  logic       reset,
    output logic       tx_bit,
    input  logic       rx_bit,
    input  logic [1:0] wb_addr,
    input  logic [7:0] wb_data_in,
    output logic [7:0] wb_data_out,
    input  logic       wb_we,
    input  logic       wb_clk,
    input  logic       wb_stb,
    output logic       wb_ack
);

    logic unused_wb_clk;
    assign unused_wb_clk = wb_clk;

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_eff;
    logic [15:0]      div_view;
    logic [7:0]       rx_data_reg;
    logic [7:0]       data_out_reg;
    logic             ack_reg;
    logic             rx_valid_reg;
    logic             overrun_reg;
    logic             frame_err_reg;

    logic       access;
    logic       wr;
    logic       rd;
    logic       rd_data;
    logic       tx_busy;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rx_ferr;
    logic [7:0] status;

    assign access   = wb_stb & ~ack_reg;
    assign wr       = access & wb_we;
    assign rd       = access & ~wb_we;
    assign rd_data  = rd && (wb_addr == ADDR_DATA);
    assign div_eff  = (div_reg < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_reg;
    assign div_view = 16'(div_reg);

    assign wb_ack      = ack_reg;
    assign wb_data_out = data_out_reg;

    always_comb begin
        status                 = '0;
        status[STAT_TX_BUSY]   = tx_busy;
        status[STAT_RX_VALID]  = rx_valid_reg;
        status[STAT_OVERRUN]   = overrun_reg;
        status[STAT_FRAME_ERR] = frame_err_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_reg       <= 1'b0;
            data_out_reg  <= '0;
            div_reg       <= DIV_W'(CLKS_PER_BIT);
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            ack_reg <= wb_stb & ~ack_reg;

            if (rd) begin
                case (wb_addr)
                    ADDR_DATA:   data_out_reg <= rx_data_reg;
                    ADDR_STATUS: data_out_reg <= status;
                    ADDR_DIV_LO: data_out_reg <= div_view[7:0];
                    ADDR_DIV_HI: data_out_reg <= div_view[15:8];
                    default:     data_out_reg <= '0;
                endcase
            end

            if (wr) begin
                case (wb_addr)
                    ADDR_STATUS: frame_err_reg <= 1'b0;
                    ADDR_DIV_LO: div_reg <= DIV_W'({div_view[15:8], wb_data_in});
                    ADDR_DIV_HI: div_reg <= DIV_W'({wb_data_in, div_view[7:0]});
                    default: ;
                endcase
            end

            if (rd_data) begin
                rx_valid_reg <= 1'b0;
                overrun_reg  <= 1'b0;
            end

            // A byte landing in the same cycle as an RXDATA read takes priority.
            if (rx_done) begin
                rx_data_reg  <= rx_byte;
                rx_valid_reg <= 1'b1;
                if (rx_valid_reg && !rd_data) overrun_reg <= 1'b1;
            end

            if (rx_ferr) frame_err_reg <= 1'b1;
        end
    end

    uart_tx #(
        .DIV_W (DIV_W)
    ) u_tx (
        .clk    (clk),
        .srst   (reset),
        .div    (div_eff),
        .start  (wr && (wb_addr == ADDR_DATA)),
        .data   (wb_data_in),
        .tx_bit (tx_bit),
        .busy   (tx_busy)
    );

    uart_rx #(
        .DIV_W       (DIV_W),
        .SYNC_STAGES (2)
    ) u_rx (
        .clk     (clk),
        .srst    (reset),
        .div     (div_eff),
        .rx_bit  (rx_bit),
        .rx_data (rx_byte),
        .rx_done (rx_done),
        .rx_ferr (rx_ferr)
    );

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: bus accesses, edge-exact TX frame capture and
// randomized RX frames scored against a simple receive-status model.
module tb_uart;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_bit;
    logic       rx_bit;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_in;
    logic [7:0] wb_data_out;
    logic       wb_we;
    logic       wb_clk;
    logic       wb_stb;
    logic       wb_ack;

    uart dut (
        .clk         (clk),
        .reset       (reset),
        .tx_bit      (tx_bit),
        .rx_bit      (rx_bit),
        .wb_addr     (wb_addr),
        .wb_data_in  (wb_data_in),
        .wb_data_out (wb_data_out),
        .wb_we       (wb_we),
        .wb_clk      (wb_clk),
        .wb_stb      (wb_stb),
        .wb_ack      (wb_ack)
    );

    always #5 clk = ~clk;
    assign wb_clk = clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Receive-side model: what the host should see in RXDATA/STATUS.
    logic [7:0] m_data  = 8'h00;
    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;
    bit         m_ferr  = 1'b0;
    int         bit_clks = 104;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus tasks are entered on a negedge; the access edge is the next posedge.
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        wb_addr = a; wb_data_in = d; wb_we = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        check_eq("wr_ack", wb_ack, 1);
        wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        $display("write addr=%0d data=0x%02h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        wb_addr = a; wb_we = 1'b0; wb_stb = 1'b1;
        @(negedge clk);
        check_eq("rd_ack", wb_ack, 1);
        d = wb_data_out;
        wb_stb = 1'b0;
        @(negedge clk);
        check_eq("ack_pulse", wb_ack, 0);
        $display("read  addr=%0d data=0x%02h", a, d);
    endtask

    function automatic logic [7:0] exp_status();
        return {4'b0, m_ferr, m_ovr, m_valid, 1'b0};
    endfunction

    task automatic check_status(input string tag);
        logic [7:0] d;
        bus_read(ADDR_STATUS, d);
        check_eq(tag, d, exp_status());
    endtask

    task automatic read_rx();
        logic [7:0] d;
        bus_read(ADDR_DATA, d);
        check_eq("rxdata", d, m_data);
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        rx_bit = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_bit = b[i];
            repeat (bit_clks) @(negedge clk);
        end
        rx_bit = stop;
        repeat (bit_clks) @(negedge clk);
        rx_bit = 1'b1;
        repeat (2) @(negedge clk);
        if (stop) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = b;
        end else begin
            m_ferr = 1'b1;
        end
        $display("rx frame 0x%02h stop=%0d", b, stop);
    endtask

    // Writes a byte, captures tx_bit every cycle, checks the busy window and
    // optionally fires a second write mid-frame that must be dropped.
    task automatic tx_frame(input logic [7:0] b, input bit try_drop);
        logic [9:0] exp_frame;
        logic [9:0] first_s;
        logic [9:0] last_s;
        int         idle_low;
        int         c;
        int         d;
        logic [7:0] st;
        d         = bit_clks;
        exp_frame = {1'b1, b, 1'b0};
        first_s   = '0;
        last_s    = '0;
        idle_low  = 0;
        fork
            begin
                for (int m = 1; m <= 12 * d; m++) begin
                    @(negedge clk);
                    if ((m - 1) % d == 0 && m <= 10 * d) first_s[(m - 1) / d] = tx_bit;
                    if (m % d == 0 && m <= 10 * d)       last_s[m / d - 1]    = tx_bit;
                    if (m > 10 * d && tx_bit !== 1'b1)   idle_low++;
                end
            end
            begin
                bus_write(ADDR_DATA, b);
                bus_read(ADDR_STATUS, st);
                check_eq("tx_busy_start", st[STAT_TX_BUSY], 1);
                c = 4;
                if (try_drop) begin
                    bus_write(ADDR_DATA, 8'h55);
                    c = 6;
                end
                repeat (10 * d - c) @(negedge clk);
                bus_read(ADDR_STATUS, st);
                check_eq("tx_busy_last", st[STAT_TX_BUSY], 1);
                bus_read(ADDR_STATUS, st);
                check_eq("tx_busy_done", st[STAT_TX_BUSY], 0);
            end
        join
        check_eq("tx_bit_first", first_s, exp_frame);
        check_eq("tx_bit_last", last_s, exp_frame);
        check_eq("tx_idle_after", idle_low, 0);
        $display("tx frame 0x%02h div=%0d", b, d);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        reset = 1'b1; rx_bit = 1'b1;
        wb_addr = '0; wb_data_in = '0; wb_we = 1'b0; wb_stb = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("reset_tx_bit", tx_bit, 1);
        check_eq("reset_ack", wb_ack, 0);
        check_eq("reset_data_out", wb_data_out, 0);
        wb_stb = 1'b0;
        reset  = 1'b0;
        @(negedge clk);

        check_status("status_reset");
        bus_read(ADDR_DIV_LO, d);
        check_eq("div_lo_reset", d, 104);
        bus_read(ADDR_DIV_HI, d);
        check_eq("div_hi_reset", d, 0);

        tx_frame(8'h41, 1'b1);

        send_rx(8'hA5, 1'b1);
        check_status("status_rx_valid");
        read_rx();
        check_status("status_after_read");

        send_rx(8'h3C, 1'b1);
        send_rx(8'hC3, 1'b1);
        check_status("status_overrun");
        read_rx();

        send_rx(8'h99, 1'b0);
        check_status("status_frame_err");
        read_rx();
        bus_write(ADDR_STATUS, 8'h00);
        m_ferr = 1'b0;
        check_status("status_ferr_clear");

        rx_bit = 1'b0;
        repeat (20) @(negedge clk);
        rx_bit = 1'b1;
        repeat (2 * bit_clks) @(negedge clk);
        check_status("status_glitch");

        bus_write(ADDR_DIV_LO, 8'd10);
        bus_write(ADDR_DIV_HI, 8'd0);
        bit_clks = 10;
        bus_read(ADDR_DIV_LO, d);
        check_eq("div_lo_10", d, 10);
        tx_frame(8'hFF, 1'b0);

        for (int it = 0; it < 10; it++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) begin
                tx_frame(b, 1'($urandom_range(0, 1)));
            end else begin
                send_rx(b, $urandom_range(0, 4) != 0);
                check_status("status_rand");
                if ($urandom_range(0, 1) == 1) read_rx();
                if (m_ferr && $urandom_range(0, 1) == 1) begin
                    bus_write(ADDR_STATUS, 8'($urandom_range(0, 255)));
                    m_ferr = 1'b0;
                end
            end
        end
        check_status("status_rand_end");

        bus_write(ADDR_DIV_LO, 8'd2);
        bus_read(ADDR_DIV_LO, d);
        check_eq("div_lo_2", d, 2);
        bit_clks = 4;
        tx_frame(8'($urandom_range(0, 255)), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- Byte-wide 8N1 UART (1 start, 8 data LSB-first, 1 stop, no parity) with a Wishbone-style slave register interface.
- Runs entirely on the 12 MHz reference clock `clk`.
- Sits between a host bus (for example RPi GPIO bridged to Wishbone) and the board's serial TX/RX pins.

Parameters:
- CLKS_PER_BIT, 104, reset value of the baud divisor (12 MHz / 115200).
- DIV_W, 16, divisor/counter width.

Ports:
- clk  in  1  reference clock, 12 MHz; sole clock for all logic
- reset  in  1  synchronous, active-high reset (1 => reset)
- tx_bit  out  1  serial TX pin; idle high
- rx_bit  in  1  serial RX pin; asynchronous, idle high
- wb_addr  in  2  register address
- wb_data_in  in  8  write data
- wb_data_out  out  8  read data, registered
- wb_we  in  1  1 = write, 0 = read
- wb_clk  in  1  bus clock pin; ignored, kept for pin compatibility (no second clock domain)
- wb_stb  in  1  strobe / chip select (acts as cyc&stb)
- wb_ack  out  1  cycle acknowledge

Behaviour:
Clocking and reset:
- One clock `clk`; reset is synchronous and active-high.
- Reset values:
  - tx_bit=1, wb_ack=0, wb_data_out=0
  - divisor=CLKS_PER_BIT
  - TX FSM=IDLE, RX FSM=IDLE
  - status flags cleared
- While reset stays high, tx_bit stays 1 and no register access is acknowledged.

Bus handshake:
- wb_ack <= wb_stb & ~wb_ack. One cycle latency, one-cycle pulse.
- Back-to-back accesses need stb held or re-asserted.
- A write or read side effect occurs exactly once, in the cycle where wb_stb=1 and wb_ack=0.
- wb_data_out is loaded in that same cycle and holds until the next read.

Register map:
- 0 write: TXDATA. Starts transmission if tx idle; ignored (byte dropped) if tx busy.
- 0 read: RXDATA (last received byte). Clears rx_valid and overrun.
- 1 read: STATUS, bit0 tx_busy, bit1 rx_valid, bit2 overrun, bit3 frame_err, bits7:4=0. Writing any value clears frame_err.
- 2 read/write: divisor[7:0].
- 3 read/write: divisor[15:8].
- Divisor values below 4 are clamped to 4.

TX FSM (IDLE, START, DATA, STOP):
- Each state lasts divisor clocks.
- DATA shifts 8 bits LSB first, using a 3-bit index that wraps 7 -> STOP.
- tx_busy=1 from the cycle after the accepted write until STOP completes: 10*divisor clocks.
- A new write is accepted in the cycle after returning to IDLE.

RX FSM (IDLE, START, DATA, STOP):
- rx_bit passes through a 2-FF synchronizer.
- IDLE: a falling level (0) moves to START.
- START: check the line at divisor/2. If high, it is a glitch: return to IDLE. Otherwise move to DATA.
- DATA: sample each bit every divisor clocks at mid-bit.
- STOP: sample the stop bit.
  - Stop=1: store the byte and set rx_valid. If rx_valid was already 1, overwrite the byte and set overrun.
  - Stop=0: discard the byte and set frame_err.
- Return to IDLE after the stop sample, i.e. mid-stop, so the next start bit is caught.

Simultaneous events:
- A read of RXDATA in the same cycle as a new byte store: the store wins, rx_valid stays 1 and the new byte is returned on the next read.
- A divisor change mid-frame takes effect at the next bit boundary.

Decomposition:
- Package uart_pkg:
  - register address constants: ADDR_DATA=0, ADDR_STATUS=1, ADDR_DIV_LO=2, ADDR_DIV_HI=3
  - status bit indices
  - FSM state enums (IDLE/START/DATA/STOP)
- Sub-modules uart_tx and uart_rx, each roughly 80 lines.
- The top level holds the bus decode, divisor and status registers.

Test Plan:
- Reset high for 10 clocks -> tx_bit=1, wb_ack=0, STATUS reads 0x00, divisor reads 104/0.
- Write 0x41 to addr 0 -> wb_ack pulses 1 cycle after stb. tx_bit shows start 0, then bits 1,0,0,0,0,0,1,0, then stop 1, each 104 clocks. STATUS bit0=1 for 1040 clocks.
- Write 0x55 while busy sending 0x41 -> 0x55 is never transmitted; the frame for 0x41 is unchanged.
- Drive 0xA5 8N1 on rx_bit at 104 clocks/bit -> STATUS=0x02. Reading addr 0 returns 0xA5; STATUS then reads 0x00.
- Send two bytes without reading -> STATUS=0x06 and RXDATA holds the second byte. Send a frame with stop=0 -> bit3 set, RXDATA unchanged. A 20-clock low glitch on rx_bit -> no byte received.
- Write divisor 10 (addr2=10, addr3=0), then transmit 0xFF -> each bit lasts 10 clocks. Write divisor 2 -> reads back 2, bit time clamped to 4 clocks.
